// File: rtl/mmu_feeder.sv
// Input skew stage for the NxN systolic array: re-times lane r by r cycles to form the wavefront.
// Optional bubble statistics (stall_cnt) are built only when MMU_FEEDER_STATS_EN is defined.
module mmu_feeder #(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned K_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_act [N],
    input  logic [DW-1:0] in_wgt [N],
    input  logic          in_last,
    output logic          valid_o,
    output logic [DW-1:0] activation_rows [N],
    output logic [DW-1:0] weight_columns [N],
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   stall_cnt
);
    localparam int unsigned BcW = $clog2(K_MAX + 1);
    localparam int unsigned DcW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BcW-1:0] BeatLimit = BcW'(K_MAX - 1);
    localparam logic [DcW-1:0] DrainLast = DcW'((N > 1) ? N - 2 : 0);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e         state_q, state_d;
    logic [BcW-1:0] beat_cnt_q, beat_cnt_d;
    logic [DcW-1:0] drain_cnt_q, drain_cnt_d;
    logic           err_q, err_d;
    logic           vld_q;
    logic           accept;
    logic           last_drain;

    assign in_ready   = ~rst & (state_q != StDrain);
    assign accept     = in_valid & in_ready;
    assign last_drain = (drain_cnt_q == DrainLast);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    beat_cnt_d  = BcW'(1);
                    drain_cnt_d = '0;
                    state_d     = in_last ? StDrain : StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BcW'(1);
                    if (in_last) begin
                        drain_cnt_d = '0;
                        state_d     = StDrain;
                    end else if (beat_cnt_q == BeatLimit) begin
                        // Overlong tile: flag it and close it out as if in_last had arrived.
                        err_d       = 1'b1;
                        drain_cnt_d = '0;
                        state_d     = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_drain) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q + DcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            vld_q       <= accept;
        end
    end

    // Lane r is a (r+1)-deep shift register; only lane 0 carries a valid bit since the
    // other lanes inherit their alignment from the skew.
    for (genvar r = 0; r < N; r++) begin : g_lane
        localparam int unsigned LW = (r + 1) * DW;
        logic [r:0][DW-1:0] act_q;
        logic [r:0][DW-1:0] wgt_q;
        logic [DW-1:0]      act_in;
        logic [DW-1:0]      wgt_in;

        assign act_in = accept ? in_act[r] : '0;
        assign wgt_in = accept ? in_wgt[r] : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                act_q <= '0;
                wgt_q <= '0;
            end else begin
                act_q <= (act_q << DW) | LW'(act_in);
                wgt_q <= (wgt_q << DW) | LW'(wgt_in);
            end
        end

        assign activation_rows[r] = act_q[r];
        assign weight_columns[r]  = wgt_q[r];
    end

    assign valid_o = vld_q;
    assign busy    = (state_q != StIdle);
    assign done    = ~rst & (state_q == StDrain) & last_drain;
    assign err     = err_q;

`ifdef MMU_FEEDER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == StStream && !in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Self-checking bench for mmu_feeder: per-cycle comparison against a history-based skew model.
module tb_mmu_feeder;
    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned K_MAX = 16;
    localparam int          HIST  = 2048;

    typedef struct packed {
        logic [N-1:0][DW-1:0] a;
        logic [N-1:0][DW-1:0] w;
        logic                 last;
        logic                 bub;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_act [N];
    logic [DW-1:0] in_wgt [N];
    logic          in_last;
    logic          valid_o;
    logic [DW-1:0] activation_rows [N];
    logic [DW-1:0] weight_columns [N];
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mmu_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_act          (in_act),
        .in_wgt          (in_wgt),
        .in_last         (in_last),
        .valid_o         (valid_o),
        .activation_rows (activation_rows),
        .weight_columns  (weight_columns),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .stall_cnt       (stall_cnt)
    );

    // Model: what entered the array-side pipe each cycle; lane r shows entry (cycle-1-r).
    logic [DW-1:0] h_act [HIST][N];
    logic [DW-1:0] h_wgt [HIST][N];
    logic          h_vld [HIST];
    int            cyc = 0;
    int            clear_upto = -1;
    int            m_phase = 0;  // 0 idle, 1 streaming, 2 draining
    int            m_beats = 0;
    int            m_drain_left = 0;
    logic          m_err = 1'b0;
    int            m_stall = 0;
    logic          m_acc;

    // Observations from the most recent cycle
    logic o_valid, o_done, o_ready, o_busy, o_err, o_zero;
    logic [15:0] o_stall;
    int   n_valid, n_ready_low;
    int   done_cycles[$];
    int   acc_cycles[$];
    beat_t q[$];
    string cur;

    task automatic clear_stats();
        n_valid = 0;
        n_ready_low = 0;
        done_cycles.delete();
        acc_cycles.delete();
    endtask

    task automatic rand_inputs();
        in_last = 1'($urandom);
        for (int r = 0; r < N; r++) begin
            in_act[r] = DW'($urandom);
            in_wgt[r] = DW'($urandom);
        end
    endtask

    task automatic step();
        logic          exp_ready, exp_busy, exp_done, exp_vld;
        logic [15:0]   exp_stall;
        logic [DW-1:0] ea, ew;
        int            src;
        #1;
        exp_ready = !rst && m_phase != 2;
        exp_busy  = m_phase != 0;
        exp_done  = !rst && m_phase == 2 && m_drain_left == 1;
        exp_vld   = (cyc - 1 > clear_upto) ? h_vld[cyc-1] : 1'b0;
`ifdef MMU_FEEDER_STATS_EN
        exp_stall = 16'(m_stall);
`else
        exp_stall = 16'h0;
`endif
        vectors++;
        if ({in_ready, busy, done, err, valid_o, stall_cnt} !==
            {exp_ready, exp_busy, exp_done, m_err, exp_vld, exp_stall}) begin
            miscompares++;
            $display("FAIL %s ctrl cyc=%0d got rdy=%b busy=%b done=%b err=%b vld=%b stall=%0d want rdy=%b busy=%b done=%b err=%b vld=%b stall=%0d",
                     cur, cyc, in_ready, busy, done, err, valid_o, stall_cnt,
                     exp_ready, exp_busy, exp_done, m_err, exp_vld, exp_stall);
        end
        o_zero = !valid_o;
        for (int r = 0; r < N; r++) begin
            src = cyc - 1 - r;
            ea  = (src > clear_upto) ? h_act[src][r] : '0;
            ew  = (src > clear_upto) ? h_wgt[src][r] : '0;
            if (activation_rows[r] != '0 || weight_columns[r] != '0) o_zero = 1'b0;
            vectors++;
            if (activation_rows[r] !== ea || weight_columns[r] !== ew) begin
                miscompares++;
                $display("FAIL %s lane%0d cyc=%0d got act=%h wgt=%h want act=%h wgt=%h",
                         cur, r, cyc, activation_rows[r], weight_columns[r], ea, ew);
            end
        end
        o_valid = valid_o;
        o_done  = done;
        o_ready = in_ready;
        o_busy  = busy;
        o_err   = err;
        o_stall = stall_cnt;
        if (o_valid) n_valid++;
        if (o_done) done_cycles.push_back(cyc);
        if (!o_ready) n_ready_low++;

        m_acc = in_valid && exp_ready;
        if (m_acc) acc_cycles.push_back(cyc);
        h_vld[cyc] = m_acc;
        for (int r = 0; r < N; r++) begin
            h_act[cyc][r] = m_acc ? in_act[r] : '0;
            h_wgt[cyc][r] = m_acc ? in_wgt[r] : '0;
        end
        if (rst) begin
            m_phase = 0;
            m_beats = 0;
            m_drain_left = 0;
            m_err = 1'b0;
            m_stall = 0;
            clear_upto = cyc;
        end else begin
            case (m_phase)
                0: if (m_acc) begin
                    m_beats = 1;
                    if (in_last) begin
                        m_phase = 2;
                        m_drain_left = (N > 1) ? int'(N) - 1 : 1;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!in_valid && m_stall < 65535) m_stall++;
                    if (m_acc) begin
                        m_beats++;
                        if (in_last || m_beats == int'(K_MAX)) begin
                            if (!in_last) m_err = 1'b1;
                            m_phase = 2;
                            m_drain_left = (N > 1) ? int'(N) - 1 : 1;
                        end
                    end
                end
                default: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= HIST) begin
            $display("FAIL %s history overflow at cyc=%0d", cur, cyc);
            $fatal(1);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'($urandom);
        rand_inputs();
        step();
        rst = 1'b0;
        idle(1);
    endtask

    task automatic push_tile(input int k, input bit pattern, input bit use_last);
        beat_t b;
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < N; r++) begin
                b.a[r] = pattern ? DW'(16 * i + r) : DW'($urandom);
                b.w[r] = pattern ? DW'(8'h80 + 16 * i + r) : DW'($urandom);
            end
            b.last = use_last && (i == k - 1);
            b.bub  = 1'b0;
            q.push_back(b);
        end
    endtask

    task automatic push_bubble();
        beat_t b;
        b = '0;
        b.bub = 1'b1;
        q.push_back(b);
    endtask

    task automatic send(input int pct);
        int guard;
        bit is_bub;
        guard = 0;
        while (q.size() > 0) begin
            is_bub = q[0].bub;
            if (is_bub || $urandom_range(99) < pct) begin
                in_valid = 1'b0;
                rand_inputs();
            end else begin
                in_valid = 1'b1;
                in_last  = q[0].last;
                for (int r = 0; r < N; r++) begin
                    in_act[r] = q[0].a[r];
                    in_wgt[r] = q[0].w[r];
                end
            end
            step();
            if (is_bub || m_acc) void'(q.pop_front());
            guard++;
            if (guard > 1000) begin
                miscompares++;
                $display("FAIL %s send timeout got %0d beats left want 0", cur, q.size());
                q.delete();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        in_valid = 1'b1;
        rand_inputs();
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 ||
            o_stall !== 16'h0 || o_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b err=%b stall=%0d zero=%b want 1 0 0 0 0 1",
                     o_ready, o_valid, o_busy, o_err, o_stall, o_zero);
        end
    endtask

    task automatic test_contig();
        int p;
        cur = "contig";
        do_reset();
        clear_stats();
        push_tile(4, 1'b1, 1'b1);
        send(0);
        idle(8);
        p = acc_cycles[0];
        vectors++;
        if (n_valid != 4 || done_cycles.size() != 1) begin
            miscompares++;
            $display("FAIL contig_counts got valid=%0d done=%0d want 4 1", n_valid, done_cycles.size());
        end else begin
            vectors++;
            if (done_cycles[0] != p + 4 + int'(N) - 2) begin
                miscompares++;
                $display("FAIL contig_done_cycle got %0d want %0d", done_cycles[0], p + 4 + int'(N) - 2);
            end
        end
    endtask

    task automatic test_bubble();
        int p;
        logic [15:0] exp_stall;
        cur = "bubble";
        do_reset();
        clear_stats();
        push_tile(2, 1'b1, 1'b0);
        push_bubble();
        push_tile(2, 1'b1, 1'b1);
        send(0);
`ifdef MMU_FEEDER_STATS_EN
        exp_stall = 16'd1;
`else
        exp_stall = 16'd0;
`endif
        idle(8);
        p = acc_cycles[0];
        vectors++;
        if (o_stall !== exp_stall || n_valid != 4 || done_cycles.size() != 1) begin
            miscompares++;
            $display("FAIL bubble_counts got stall=%0d valid=%0d done=%0d want %0d 4 1",
                     o_stall, n_valid, done_cycles.size(), exp_stall);
        end else begin
            vectors++;
            if (done_cycles[0] != p + 5 + int'(N) - 2) begin
                miscompares++;
                $display("FAIL bubble_done_cycle got %0d want %0d", done_cycles[0], p + 5 + int'(N) - 2);
            end
        end
    endtask

    task automatic test_k1();
        cur = "k1";
        do_reset();
        clear_stats();
        push_tile(1, 1'b0, 1'b1);
        send(0);
        idle(6);
        vectors++;
        if (n_valid != 1 || done_cycles.size() != 1) begin
            miscompares++;
            $display("FAIL k1_counts got valid=%0d done=%0d want 1 1", n_valid, done_cycles.size());
        end else begin
            vectors++;
            if (done_cycles[0] != acc_cycles[0] + int'(N) - 1) begin
                miscompares++;
                $display("FAIL k1_done_cycle got %0d want %0d", done_cycles[0], acc_cycles[0] + int'(N) - 1);
            end
        end
    endtask

    task automatic test_overflow();
        cur = "overflow";
        do_reset();
        clear_stats();
        push_tile(16, 1'b0, 1'b0);
        send(0);
        n_ready_low = 0;
        push_tile(3, 1'b0, 1'b1);
        send(0);
        vectors++;
        if (n_ready_low != int'(N) - 1) begin
            miscompares++;
            $display("FAIL overflow_ready_low got %0d want %0d", n_ready_low, int'(N) - 1);
        end
        idle(6);
        vectors++;
        if (o_err !== 1'b1 || done_cycles.size() != 2 || n_valid != 19) begin
            miscompares++;
            $display("FAIL overflow_end got err=%b done=%0d valid=%0d want 1 2 19",
                     o_err, done_cycles.size(), n_valid);
        end
    endtask

    task automatic test_reset_drain();
        cur = "reset_drain";
        do_reset();
        clear_stats();
        push_tile(5, 1'b0, 1'b1);
        send(0);
        idle(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (o_zero !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drain_state got zero=%b busy=%b rdy=%b done=%b want 1 0 1 0",
                     o_zero, o_busy, o_ready, o_done);
        end
        idle(4);
        vectors++;
        if (done_cycles.size() != 0) begin
            miscompares++;
            $display("FAIL reset_drain_done got %0d pulses want 0", done_cycles.size());
        end
    endtask

    task automatic test_back_to_back();
        cur = "back_to_back";
        do_reset();
        clear_stats();
        push_tile(3, 1'b1, 1'b1);
        push_tile(2, 1'b0, 1'b1);
        send(0);
        idle(6);
        vectors++;
        if (done_cycles.size() != 2 || acc_cycles.size() != 5) begin
            miscompares++;
            $display("FAIL b2b_counts got done=%0d acc=%0d want 2 5", done_cycles.size(), acc_cycles.size());
        end else begin
            vectors++;
            if (acc_cycles[3] != done_cycles[0] + 1) begin
                miscompares++;
                $display("FAIL b2b_second_accept got %0d want %0d", acc_cycles[3], done_cycles[0] + 1);
            end
        end
    endtask

    task automatic test_random();
        int tiles;
        cur = "random";
        do_reset();
        clear_stats();
        tiles = 12;
        for (int t = 0; t < tiles; t++) begin
            push_tile($urandom_range(K_MAX, 1), 1'b0, 1'b1);
            send(25);
        end
        idle(6);
        vectors++;
        if (done_cycles.size() != tiles || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL random_end got done=%0d err=%b want %0d 0", done_cycles.size(), o_err, tiles);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        rand_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_contig();
        test_bubble();
        test_k1();
        test_overflow();
        test_reset_drain();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
